// File: rtl/tb_traffic_sequencer.sv
// AXI4 write/read-back traffic sequencer for memory unit benches.
// Status (done/error/iter) is sticky so a bench only watches done_o and error_o.
package tb_traffic_sequencer_pkg;
   localparam int unsigned AW = 48;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 6;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [2:0]    size;
      logic [1:0]    burst;
      logic          lock;
      logic [3:0]    cache;
      logic [2:0]    prot;
      logic [3:0]    qos;
      logic [3:0]    region;
   } ax_chan_t;

   typedef struct packed {
      logic [DW-1:0]   data;
      logic [DW/8-1:0] strb;
      logic            last;
   } w_chan_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [1:0]    resp;
   } b_chan_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;
endpackage

module tb_traffic_sequencer #(
   parameter type                   axi_req_t   = tb_traffic_sequencer_pkg::axi_req_t,
   parameter type                   axi_rsp_t   = tb_traffic_sequencer_pkg::axi_rsp_t,
   parameter int unsigned           AddrWidth   = 48,
   parameter int unsigned           DataWidth   = 64,
   parameter int unsigned           IdWidth     = 6,
   parameter logic [AddrWidth-1:0]  BaseAddr    = '0,
   parameter int unsigned           RegionBytes = 4096,
   parameter int unsigned           BurstLen    = 4,
   parameter int unsigned           NumIter     = 16,
   parameter int unsigned           TxnId       = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   output axi_req_t                     axi_req_o,
   input  axi_rsp_t                     axi_rsp_i,
   input  logic                         mismatch_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         error_o,
   output logic [$clog2(NumIter+1)-1:0] iter_o
);

   localparam int unsigned BeatBytes  = DataWidth / 8;
   localparam int unsigned BurstBytes = BurstLen * BeatBytes;
   localparam int unsigned BeatW      = (BurstLen > 1) ? $clog2(BurstLen) : 1;
   localparam int unsigned IterW      = $clog2(NumIter + 1);

   localparam logic [AddrWidth-1:0] RegionEnd = BaseAddr + AddrWidth'(RegionBytes);
   localparam logic [BeatW-1:0]     LastBeat  = BeatW'(BurstLen - 1);
   localparam logic [IterW-1:0]     IterEnd   = IterW'(NumIter);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AW   = 3'd1;
   localparam logic [2:0] S_W    = 3'd2;
   localparam logic [2:0] S_B    = 3'd3;
   localparam logic [2:0] S_AR   = 3'd4;
   localparam logic [2:0] S_R    = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   if ((DataWidth % 32) != 0) begin : g_chk_dw
      $fatal(1, "DataWidth must be a multiple of 32");
   end
   if ((RegionBytes % BurstBytes) != 0) begin : g_chk_region
      $fatal(1, "RegionBytes must be a multiple of the burst size");
   end
   // Aligned bursts never straddle 4 KiB when the burst size divides 4 KiB.
   if ((BurstBytes > 4096) || ((4096 % BurstBytes) != 0) ||
       ((BaseAddr % AddrWidth'(BurstBytes)) != '0)) begin : g_chk_4k
      $fatal(1, "burst would cross a 4 KiB boundary");
   end

   logic [2:0]           r_state;
   logic [AddrWidth-1:0] r_cur_addr;
   logic [BeatW-1:0]     r_beat_cnt;
   logic [IterW-1:0]     r_iter;
   logic                 r_error;

   logic                 w_last_beat;
   logic [AddrWidth-1:0] w_beat_addr;
   logic [AddrWidth-1:0] w_next_addr;
   logic [IterW-1:0]     w_iter_inc;
   logic [31:0]          w_word;
   logic                 w_unused;

   assign w_last_beat = (r_beat_cnt == LastBeat);
   assign w_beat_addr = r_cur_addr + AddrWidth'(r_beat_cnt) * AddrWidth'(BeatBytes);
   assign w_next_addr = r_cur_addr + AddrWidth'(BurstBytes);
   assign w_iter_inc  = r_iter + IterW'(1);
   assign w_word      = w_beat_addr[31:0] ^ {16'(r_iter), 16'h0000};
   assign w_unused    = ^{axi_rsp_i, w_beat_addr};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_cur_addr <= BaseAddr;
         r_beat_cnt <= '0;
         r_iter     <= '0;
         r_error    <= 1'b0;
      end else begin
         // The comparator reports late, so mismatches still count in DONE.
         if ((r_state != S_IDLE) && mismatch_i) begin
            r_error <= 1'b1;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  r_error    <= 1'b0;
                  r_iter     <= '0;
                  r_beat_cnt <= '0;
                  r_cur_addr <= BaseAddr;
                  r_state    <= S_AW;
               end
            end
            S_AW: begin
               if (axi_rsp_i.aw_ready) begin
                  r_state <= S_W;
               end
            end
            S_W: begin
               if (axi_rsp_i.w_ready) begin
                  if (w_last_beat) begin
                     r_beat_cnt <= '0;
                     r_state    <= S_B;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BeatW'(1);
                  end
               end
            end
            S_B: begin
               if (axi_rsp_i.b_valid) begin
                  if (axi_rsp_i.b.resp != 2'b00) begin
                     r_error <= 1'b1;
                  end
                  r_state <= S_AR;
               end
            end
            S_AR: begin
               if (axi_rsp_i.ar_ready) begin
                  r_state <= S_R;
               end
            end
            S_R: begin
               if (axi_rsp_i.r_valid) begin
                  if ((axi_rsp_i.r.last != w_last_beat) || (axi_rsp_i.r.resp != 2'b00) ||
                      (axi_rsp_i.r.id != IdWidth'(TxnId))) begin
                     r_error <= 1'b1;
                  end
                  if (w_last_beat) begin
                     r_beat_cnt <= '0;
                     r_iter     <= w_iter_inc;
                     r_cur_addr <= (w_next_addr == RegionEnd) ? BaseAddr : w_next_addr;
                     r_state    <= (w_iter_inc == IterEnd) ? S_DONE : S_AW;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BeatW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Request fields depend on state and registers only, never on a ready.
   always_comb begin
      axi_req_o = '0;
      case (r_state)
         S_AW: begin
            axi_req_o.aw_valid = 1'b1;
            axi_req_o.aw.addr  = r_cur_addr;
            axi_req_o.aw.len   = 8'(BurstLen - 1);
            axi_req_o.aw.size  = 3'($clog2(BeatBytes));
            axi_req_o.aw.burst = 2'b01;
            axi_req_o.aw.id    = IdWidth'(TxnId);
         end
         S_W: begin
            axi_req_o.w_valid = 1'b1;
            axi_req_o.w.data  = {(DataWidth/32){w_word}};
            axi_req_o.w.strb  = '1;
            axi_req_o.w.last  = w_last_beat;
         end
         S_B: axi_req_o.b_ready = 1'b1;
         S_AR: begin
            axi_req_o.ar_valid = 1'b1;
            axi_req_o.ar.addr  = r_cur_addr;
            axi_req_o.ar.len   = 8'(BurstLen - 1);
            axi_req_o.ar.size  = 3'($clog2(BeatBytes));
            axi_req_o.ar.burst = 2'b01;
            axi_req_o.ar.id    = IdWidth'(TxnId);
         end
         S_R: axi_req_o.r_ready = 1'b1;
         default: ;
      endcase
   end

   assign busy_o  = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done_o  = (r_state == S_DONE);
   assign error_o = r_error;
   assign iter_o  = r_iter;

endmodule

// File: tb/tb_tb_traffic_sequencer.sv
// Bench for tb_traffic_sequencer: a reactive AXI slave with an 8-word memory
// and a scoreboard of expected AW/W/AR traffic for a 64-byte, 5-iteration run.
module tb_tb_traffic_sequencer;
   import tb_traffic_sequencer_pkg::*;

   localparam logic [47:0] AW_TAB [5] = '{48'h00, 48'h20, 48'h00, 48'h20, 48'h00};

   logic     clk_i = 1'b0;
   logic     rst_ni;
   logic     start_i;
   logic     mismatch_i;
   axi_req_t axi_req;
   axi_rsp_t axi_rsp;
   logic     busy_o, done_o, error_o;
   logic [2:0] iter_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_aw[$];
   logic [63:0] exp_ar[$];
   logic [63:0] exp_w[$];

   // slave configuration and bookkeeping
   int          aw_stall;
   int          b_err_at;
   int          r_bad_iter;
   int          aw_wait_cnt, aw_hs, b_idx, r_total, r_iter_cnt, w_total;
   int          w_beat, r_beat;
   bit          aw_waiting, b_pending, r_pending, chk_err_rise;
   logic [47:0] aw_hold, w_addr, r_addr;
   logic [63:0] mem [8];

   always #5 clk_i = ~clk_i;

   tb_traffic_sequencer #(
      .axi_req_t   (axi_req_t),
      .axi_rsp_t   (axi_rsp_t),
      .AddrWidth   (48),
      .DataWidth   (64),
      .IdWidth     (6),
      .BaseAddr    (48'h0),
      .RegionBytes (64),
      .BurstLen    (4),
      .NumIter     (5),
      .TxnId       (5)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .axi_req_o  (axi_req),
      .axi_rsp_i  (axi_rsp),
      .mismatch_i (mismatch_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o),
      .iter_o     (iter_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Slave + monitor: decides readies/responses each negedge and pops the
   // scoreboard for every handshake that will complete at the next posedge.
   initial begin
      axi_rsp = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            axi_rsp      = '0;
            aw_waiting   = 0;
            aw_wait_cnt  = 0;
            b_pending    = 0;
            r_pending    = 0;
            chk_err_rise = 0;
            continue;
         end
         if (chk_err_rise) begin
            chk("b_err_rise", error_o, 1'b1);
            chk_err_rise = 0;
         end
         axi_rsp          = '0;
         axi_rsp.w_ready  = 1'b1;
         axi_rsp.ar_ready = 1'b1;
         if (b_pending) begin
            axi_rsp.b_valid = 1'b1;
            axi_rsp.b.id    = 6'd5;
            axi_rsp.b.resp  = (b_idx + 1 == b_err_at) ? 2'b10 : 2'b00;
            if (axi_req.b_ready) begin
               b_idx++;
               b_pending = 0;
               if (b_idx == b_err_at) begin
                  chk("b_err_pre", error_o, 1'b0);
                  chk_err_rise = 1;
               end
            end
         end
         if (r_pending) begin
            axi_rsp.r_valid = 1'b1;
            axi_rsp.r.id    = 6'd5;
            axi_rsp.r.data  = mem[(int'(r_addr[5:3]) + r_beat) % 8];
            axi_rsp.r.last  = (r_beat == 3) || (r_iter_cnt == r_bad_iter && r_beat == 2);
            if (axi_req.r_ready) begin
               r_beat++;
               r_total++;
               if (r_beat == 4) begin
                  r_pending = 0;
                  r_iter_cnt++;
               end
            end
         end
         if (axi_req.w_valid) begin
            if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
            else chk("w_data", axi_req.w.data, exp_w.pop_front());
            chk("w_last", axi_req.w.last, (w_beat == 3));
            chk("w_strb", axi_req.w.strb, 8'hFF);
            if (w_total == 9) chk("w_iter2_beat1", axi_req.w.data, 64'h00020008_00020008);
            mem[(int'(w_addr[5:3]) + w_beat) % 8] = axi_req.w.data;
            w_beat++;
            w_total++;
            if (w_beat == 4) b_pending = 1;
         end
         if (axi_req.aw_valid) begin
            if (aw_waiting) chk("aw_stable", axi_req.aw.addr, aw_hold);
            if (aw_wait_cnt < aw_stall) begin
               if (!aw_waiting) begin
                  aw_waiting = 1;
                  aw_hold    = axi_req.aw.addr;
               end
               aw_wait_cnt++;
            end else begin
               axi_rsp.aw_ready = 1'b1;
               aw_waiting  = 0;
               aw_wait_cnt = 0;
               aw_hs++;
               $display("AW handshake addr=%h", axi_req.aw.addr);
               if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
               else chk("aw_addr", 64'(axi_req.aw.addr), exp_aw.pop_front());
               chk("aw_fields", {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.id},
                   {8'd3, 3'd3, 2'b01, 6'd5});
               w_addr = axi_req.aw.addr;
               w_beat = 0;
            end
         end else if (aw_waiting) begin
            chk("aw_valid_held", 0, 1);
            aw_waiting = 0;
         end
         if (axi_req.ar_valid) begin
            $display("AR handshake addr=%h", axi_req.ar.addr);
            if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("ar_addr", 64'(axi_req.ar.addr), exp_ar.pop_front());
            r_addr    = axi_req.ar.addr;
            r_beat    = 0;
            r_pending = 1;
         end
      end
   end

   task automatic prep_run();
      exp_aw.delete();
      exp_ar.delete();
      exp_w.delete();
      for (int i = 0; i < 5; i++) begin
         exp_aw.push_back(64'(AW_TAB[i]));
         exp_ar.push_back(64'(AW_TAB[i]));
         for (int b = 0; b < 4; b++) begin
            logic [31:0] word;
            word = (32'(AW_TAB[i]) + 32'(8 * b)) ^ (32'(i) << 16);
            exp_w.push_back({word, word});
         end
      end
      aw_hs = 0; b_idx = 0; r_total = 0; r_iter_cnt = 0; w_total = 0;
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      $display("start %s", tag);
      chk("start_aw_valid", axi_req.aw_valid, 1'b1);
      chk("start_busy", busy_o, 1'b1);
      chk("start_error_clr", error_o, 1'b0);
      chk("start_done_clr", done_o, 1'b0);
   endtask

   task automatic finish_run(input logic exp_err);
      for (int i = 0; i < 1500; i++) begin
         if (done_o) break;
         @(negedge clk_i);
      end
      chk("run_done", done_o, 1'b1);
      chk("run_busy", busy_o, 1'b0);
      chk("run_iter", iter_o, 3'd5);
      chk("run_error", error_o, exp_err);
      chk("run_aw_count", aw_hs, 5);
      chk("run_r_beats", r_total, 20);
      chk("run_queues_empty", exp_aw.size() + exp_ar.size() + exp_w.size(), 0);
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; mismatch_i = 1'b0;
      aw_stall = 0; b_err_at = 0; r_bad_iter = -1;
      w_beat = 0; r_beat = 0;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_error", error_o, 1'b0);
      chk("rst_iter", iter_o, 3'd0);
      chk("rst_req", |axi_req, 1'b0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("idle_no_start", busy_o, 1'b0);

      prep_run();
      pulse_start("ideal");
      finish_run(1'b0);

      // late mismatch while in DONE must still be recorded
      mismatch_i = 1'b1;
      @(negedge clk_i);
      mismatch_i = 1'b0;
      chk("mismatch_in_done", error_o, 1'b1);
      chk("done_held", done_o, 1'b1);

      aw_stall = 7; b_err_at = 2;
      prep_run();
      pulse_start("aw_stall_b_slverr");
      finish_run(1'b1);
      aw_stall = 0; b_err_at = 0;

      r_bad_iter = 1;
      prep_run();
      pulse_start("early_rlast");
      finish_run(1'b1);
      r_bad_iter = -1;

      prep_run();
      pulse_start("reset_mid_w");
      begin
         bit found = 0;
         for (int i = 0; i < 200; i++) begin
            if (axi_req.w_valid && axi_req.w.data[31:0] == 32'h10) begin
               found = 1;
               break;
            end
            @(negedge clk_i);
         end
         chk("reach_w_beat2", found, 1'b1);
      end
      #2 rst_ni = 1'b0;
      @(negedge clk_i);
      chk("midrst_busy", busy_o, 1'b0);
      chk("midrst_done", done_o, 1'b0);
      chk("midrst_error", error_o, 1'b0);
      chk("midrst_iter", iter_o, 3'd0);
      chk("midrst_req", |axi_req, 1'b0);
      exp_aw.delete(); exp_ar.delete(); exp_w.delete();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_idle", busy_o, 1'b0);

      prep_run();
      pulse_start("after_reset");
      finish_run(1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
